booth_mac_accumulator: RTL and testbench

Signed multiply-accumulate back end for the radix-4 Booth multiplier. It is instantiated directly downstream of `multiplier` and consumes its `M` product bus. The block tracks operand validity through the multiplier's pipeline and accumulates signed products into groups delimited by a `last` flag. It emits one saturated sum per group through a two-entry output FIFO with valid/ready backpressure.

---
 rtl/booth_mac_accumulator_if.sv | 33 +++
 rtl/booth_mac_accumulator.sv | 158 +++++++++++++++
 tb/tb_booth_mac_accumulator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mac_accumulator_if.sv
//------------------------------------------------------------------------------
// Module      : booth_mac_accumulator_if
// Description : Operand-side and result-side handshake bundle for the Booth
//               MAC accumulator. The master drives operands and takes results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface booth_mac_accumulator_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40
);
  logic                          in_valid;
  logic                          in_last;
  logic                          in_ready;
  logic signed [2*WIDTH-1:0]     product;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [ACC_WIDTH-1:0]   out_acc;
  logic                          out_sat;

  modport master (
    output in_valid, in_last, product, out_ready,
    input  in_ready, out_valid, out_acc, out_sat
  );

  modport slave (
    input  in_valid, in_last, product, out_ready,
    output in_ready, out_valid, out_acc, out_sat
  );
endinterface

`default_nettype wire

// File: rtl/booth_mac_accumulator.sv
//------------------------------------------------------------------------------
// Module      : booth_mac_accumulator
// Description : Saturating signed multiply-accumulate back end. Tracks operand
//               validity through the multiplier latency, sums products per
//               group and queues one result per group in a 2-entry FIFO.
//               Input credit guarantees the FIFO can never overflow.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_mac_accumulator #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int MUL_LAT   = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  clear_i,
  booth_mac_accumulator_if.slave     mac_if
);

  localparam int LIF_W = $clog2(MUL_LAT + 1);
  localparam logic signed [ACC_WIDTH-1:0] C_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] C_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Delay line of {valid, last} aligned with the multiplier pipeline
  logic [MUL_LAT-1:0]          dv_q, dv_d;
  logic [MUL_LAT-1:0]          dl_q, dl_d;
  logic [LIF_W-1:0]            lif_q, lif_d;

  // Group accumulator state
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        gsat_q, gsat_d;

  // Result FIFO
  logic signed [ACC_WIDTH-1:0] mem_acc_q [0:1];
  logic signed [ACC_WIDTH-1:0] mem_acc_d [0:1];
  logic                        mem_sat_q [0:1];
  logic                        mem_sat_d [0:1];
  logic                        wp_q, wp_d, rp_q, rp_d;
  logic [1:0]                  cnt_q, cnt_d;

  logic                        accept, acc_last, tap_v, tap_l, push, pop, ovf;
  logic signed [ACC_WIDTH:0]   sum_ext;
  logic signed [ACC_WIDTH-1:0] sum_sat;

  // Credit depends only on registered state so in_ready has no input path
  assign mac_if.in_ready  = rst_n & ((32'(cnt_q) + 32'(lif_q)) < 32'd2);
  assign mac_if.out_valid = (cnt_q != 2'd0);
  assign mac_if.out_acc   = mem_acc_q[rp_q];
  assign mac_if.out_sat   = mem_sat_q[rp_q];

  assign accept   = mac_if.in_valid & mac_if.in_ready & ~clear_i;
  assign acc_last = accept & mac_if.in_last;
  assign tap_v    = dv_q[MUL_LAT-1];
  assign tap_l    = dl_q[MUL_LAT-1] & tap_v;
  assign push     = tap_l;
  assign pop      = mac_if.out_valid & mac_if.out_ready;

  // One extra bit catches overflow; the top two bits disagree on overflow
  assign sum_ext = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH+1-2*WIDTH){mac_if.product[2*WIDTH-1]}}, mac_if.product};
  assign ovf     = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
  assign sum_sat = ovf ? (sum_ext[ACC_WIDTH] ? C_ACC_MIN : C_ACC_MAX)
                       : sum_ext[ACC_WIDTH-1:0];

  // Next-state for delay line, accumulator and FIFO; clear overrides everything
  always_comb begin
    dv_d         = dv_q;
    dl_d         = dl_q;
    lif_d        = lif_q;
    acc_d        = acc_q;
    gsat_d       = gsat_q;
    mem_acc_d[0] = mem_acc_q[0];
    mem_acc_d[1] = mem_acc_q[1];
    mem_sat_d[0] = mem_sat_q[0];
    mem_sat_d[1] = mem_sat_q[1];
    wp_d         = wp_q;
    rp_d         = rp_q;
    cnt_d        = cnt_q;
    if (clear_i) begin
      dv_d         = '0;
      dl_d         = '0;
      lif_d        = '0;
      acc_d        = '0;
      gsat_d       = 1'b0;
      mem_acc_d[0] = '0;
      mem_acc_d[1] = '0;
      mem_sat_d[0] = 1'b0;
      mem_sat_d[1] = 1'b0;
      wp_d         = 1'b0;
      rp_d         = 1'b0;
      cnt_d        = 2'd0;
    end else begin
      dv_d[0] = accept;
      dl_d[0] = acc_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        dv_d[i] = dv_q[i-1];
        dl_d[i] = dl_q[i-1];
      end
      if (acc_last && !tap_l)      lif_d = lif_q + LIF_W'(1);
      else if (!acc_last && tap_l) lif_d = lif_q - LIF_W'(1);

      if (tap_v) begin
        if (tap_l) begin
          acc_d  = '0;
          gsat_d = 1'b0;
        end else begin
          acc_d  = sum_sat;
          gsat_d = gsat_q | ovf;
        end
      end

      if (push) begin
        mem_acc_d[wp_q] = sum_sat;
        mem_sat_d[wp_q] = gsat_q | ovf;
        wp_d            = ~wp_q;
      end
      if (pop) rp_d = ~rp_q;
      if (push && !pop)      cnt_d = cnt_q + 2'd1;
      else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q         <= '0;
      dl_q         <= '0;
      lif_q        <= '0;
      acc_q        <= '0;
      gsat_q       <= 1'b0;
      mem_acc_q[0] <= '0;
      mem_acc_q[1] <= '0;
      mem_sat_q[0] <= 1'b0;
      mem_sat_q[1] <= 1'b0;
      wp_q         <= 1'b0;
      rp_q         <= 1'b0;
      cnt_q        <= 2'd0;
    end else begin
      dv_q         <= dv_d;
      dl_q         <= dl_d;
      lif_q        <= lif_d;
      acc_q        <= acc_d;
      gsat_q       <= gsat_d;
      mem_acc_q[0] <= mem_acc_d[0];
      mem_acc_q[1] <= mem_acc_d[1];
      mem_sat_q[0] <= mem_sat_d[0];
      mem_sat_q[1] <= mem_sat_d[1];
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_mac_accumulator.sv
//------------------------------------------------------------------------------
// Module      : tb_booth_mac_accumulator
// Description : Directed bench for booth_mac_accumulator. A 40-bit and a 32-bit
//               accumulator instance share the same stimulus; a small pipeline
//               stands in for the upstream multiplier.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_booth_mac_accumulator;

  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] opa = '0;
  logic signed [15:0] opb = '0;
  logic signed [31:0] prod_pipe [0:MUL_LAT-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Multiplier stand-in: product appears MUL_LAT cycles after its operands
  always @(posedge clk) begin
    prod_pipe[0] <= opa * opb;
    for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
  end

  booth_mac_accumulator_if #(.WIDTH(16), .ACC_WIDTH(40)) if40 ();
  booth_mac_accumulator_if #(.WIDTH(16), .ACC_WIDTH(32)) if32 ();

  assign if40.in_valid  = in_valid;
  assign if40.in_last   = in_last;
  assign if40.product   = prod_pipe[MUL_LAT-1];
  assign if40.out_ready = out_ready;
  assign if32.in_valid  = in_valid;
  assign if32.in_last   = in_last;
  assign if32.product   = prod_pipe[MUL_LAT-1];
  assign if32.out_ready = out_ready;

  booth_mac_accumulator #(.WIDTH(16), .ACC_WIDTH(40), .MUL_LAT(MUL_LAT)) dut40 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .mac_if(if40.slave)
  );

  booth_mac_accumulator #(.WIDTH(16), .ACC_WIDTH(32), .MUL_LAT(MUL_LAT)) dut32 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .mac_if(if32.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input bit last);
    opa      = 16'(a);
    opb      = 16'(b);
    in_valid = 1'b1;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if40.out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!if40.out_valid) begin
      errors++;
      $display("FAIL %s_timeout out_valid got 0 exp 1", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (if40.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", if40.out_valid); end
    checks++; if (if40.out_acc !== 40'sd0) begin errors++; $display("FAIL rst_out_acc got %0d exp 0", if40.out_acc); end
    checks++; if (if40.out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat got %0b exp 0", if40.out_sat); end
    checks++; if (if40.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", if40.in_ready); end
    rst_n = 1'b1;
    step();
    checks++; if (if40.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %0b exp 1", if40.in_ready); end
  endtask

  task automatic test_group_latency();
    checks++; if (if40.in_ready !== 1'b1) begin errors++; $display("FAIL grp_in_ready got %0b exp 1", if40.in_ready); end
    send(2, 3, 1'b0);
    send(-4, 5, 1'b0);
    send(10, 10, 1'b1);
    checks++; if (if40.out_valid !== 1'b0) begin errors++; $display("FAIL grp_valid_t1 got %0b exp 0", if40.out_valid); end
    step();
    checks++; if (if40.out_valid !== 1'b0) begin errors++; $display("FAIL grp_valid_t2 got %0b exp 0", if40.out_valid); end
    step();
    checks++; if (if40.out_valid !== 1'b1) begin errors++; $display("FAIL grp_valid_t3 got %0b exp 1", if40.out_valid); end
    checks++; if (if40.out_acc !== 40'sd86) begin errors++; $display("FAIL grp_acc got %0d exp 86", if40.out_acc); end
    checks++; if (if40.out_sat !== 1'b0) begin errors++; $display("FAIL grp_sat got %0b exp 0", if40.out_sat); end
    step();
    checks++; if (if40.out_acc !== 40'sd86) begin errors++; $display("FAIL grp_hold_acc got %0d exp 86", if40.out_acc); end
    pop();
    checks++; if (if40.out_valid !== 1'b0) begin errors++; $display("FAIL grp_after_pop got %0b exp 0", if40.out_valid); end
  endtask

  task automatic test_single_min();
    send(-32768, -32768, 1'b1);
    wait_valid("single");
    checks++; if (if40.out_acc !== 40'sd1073741824) begin errors++; $display("FAIL single_acc got %0d exp 1073741824", if40.out_acc); end
    checks++; if (if40.out_sat !== 1'b0) begin errors++; $display("FAIL single_sat got %0b exp 0", if40.out_sat); end
    pop();
  endtask

  task automatic test_saturation();
    send(-32768, -32768, 1'b0);
    send(-32768, -32768, 1'b0);
    send(-32768, -32768, 1'b1);
    wait_valid("sat");
    checks++; if (if32.out_acc !== 32'sd2147483647) begin errors++; $display("FAIL sat32_acc got %0d exp 2147483647", if32.out_acc); end
    checks++; if (if32.out_sat !== 1'b1) begin errors++; $display("FAIL sat32_flag got %0b exp 1", if32.out_sat); end
    checks++; if (if40.out_acc !== 40'sd3221225472) begin errors++; $display("FAIL sat40_acc got %0d exp 3221225472", if40.out_acc); end
    checks++; if (if40.out_sat !== 1'b0) begin errors++; $display("FAIL sat40_flag got %0b exp 0", if40.out_sat); end
    pop();
    send(5, 1, 1'b1);
    wait_valid("after_sat");
    checks++; if (if32.out_acc !== 32'sd5) begin errors++; $display("FAIL after_sat_acc got %0d exp 5", if32.out_acc); end
    checks++; if (if32.out_sat !== 1'b0) begin errors++; $display("FAIL after_sat_flag got %0b exp 0", if32.out_sat); end
    pop();
  endtask

  task automatic test_back_to_back();
    checks++; if (if40.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %0b exp 1", if40.in_ready); end
    send(3, 1, 1'b0);
    checks++; if (if40.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %0b exp 1", if40.in_ready); end
    send(4, 1, 1'b1);
    checks++; if (if40.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %0b exp 1", if40.in_ready); end
    send(-7, 1, 1'b1);
    wait_valid("b2b_first");
    checks++; if (if40.out_acc !== 40'sd7) begin errors++; $display("FAIL b2b_first got %0d exp 7", if40.out_acc); end
    pop();
    wait_valid("b2b_second");
    checks++; if (if40.out_acc !== -40'sd7) begin errors++; $display("FAIL b2b_second got %0d exp -7", if40.out_acc); end
    pop();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(1, 1, 1'b1);
    send(2, 1, 1'b1);
    checks++; if (if40.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %0b exp 0", if40.in_ready); end
    opa = 16'sd3; opb = 16'sd1; in_valid = 1'b1; in_last = 1'b1;
    repeat (4) step();
    checks++; if (if40.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b exp 0", if40.in_ready); end
    checks++; if (if40.out_acc !== 40'sd1) begin errors++; $display("FAIL bp_first got %0d exp 1", if40.out_acc); end
    out_ready = 1'b1;
    checks++; if (if40.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_pop_cycle got %0b exp 0", if40.in_ready); end
    step();
    out_ready = 1'b0;
    checks++; if (if40.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %0b exp 1", if40.in_ready); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (if40.out_acc !== 40'sd2) begin errors++; $display("FAIL bp_second got %0d exp 2", if40.out_acc); end
    pop();
    wait_valid("bp_third");
    checks++; if (if40.out_acc !== 40'sd3) begin errors++; $display("FAIL bp_third got %0d exp 3", if40.out_acc); end
    pop();
    repeat (3) step();
    checks++; if (if40.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b exp 0", if40.out_valid); end
  endtask

  task automatic test_flush(input bit use_reset);
    send(9, 1, 1'b1);
    send(10, 1, 1'b0);
    send(20, 1, 1'b0);
    if (use_reset) rst_n = 1'b0; else clear = 1'b1;
    step();
    rst_n = 1'b1;
    clear = 1'b0;
    checks++; if (if40.out_valid !== 1'b0) begin errors++; $display("FAIL flush%0b_valid got %0b exp 0", use_reset, if40.out_valid); end
    send(1, 1, 1'b1);
    wait_valid("flush");
    checks++; if (if40.out_acc !== 40'sd1) begin errors++; $display("FAIL flush%0b_acc got %0d exp 1", use_reset, if40.out_acc); end
    checks++; if (if40.out_sat !== 1'b0) begin errors++; $display("FAIL flush%0b_sat got %0b exp 0", use_reset, if40.out_sat); end
    pop();
    repeat (4) step();
    checks++; if (if40.out_valid !== 1'b0) begin errors++; $display("FAIL flush%0b_stale got %0b exp 0", use_reset, if40.out_valid); end
  endtask

  initial begin
    test_reset();
    test_group_latency();
    test_single_min();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
